// File: rtl/cpu_pkg.sv
// Shared execute-stage types: instruction/opcode encodings, ID/EX payload, mul/div FSM states.
// Used by ex_stage, ex_muldiv and ex_stage_if.
package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int MD_STEPS = XLEN;

    typedef logic signed [XLEN-1:0] sint32_t;

    typedef enum logic [4:0] {
        NA   = 5'd0,
        ADD  = 5'd1,
        SUB  = 5'd2,
        AND  = 5'd3,
        OR   = 5'd4,
        SLT  = 5'd5,
        ADDI = 5'd6,
        MUL  = 5'd7,
        DIV  = 5'd8,
        XOR  = 5'd9
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instruction_t;

    typedef struct packed {
        instruction_t IR;
        sint32_t      A;
        sint32_t      B;
        sint32_t      Imm;
    } ID_EX_pipe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic instruction_t bubble_ir();
        instruction_t ir;
        ir        = '0;
        ir.opcode = NA;
        return ir;
    endfunction

    // INT_MIN maps to 32'h8000_0000, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs32(sint32_t v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX-to-EX/WB signal bundle; master drives the decoded instruction and flush,
// slave (ex_stage) returns stall, the next IR/result pair and the mul/div busy flag.
interface ex_stage_if;
    import cpu_pkg::*;

    ID_EX_pipe_t  id_ex_pipe;
    logic         flush;
    logic         stall;
    instruction_t IR_next;
    sint32_t      C_next;
    logic         md_busy;

    modport master (
        output id_ex_pipe, flush,
        input  stall, IR_next, C_next, md_busy
    );

    modport slave (
        input  id_ex_pipe, flush,
        output stall, IR_next, C_next, md_busy
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative signed MUL (shift-add) / DIV (restoring) unit: accept -> 32 RUN steps -> DONE.
// Result valid while done_o; flush_i or resetn aborts to IDLE with no result.
module ex_muldiv
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    start_i,
    input  logic    is_div_i,
    input  logic    flush_i,
    input  sint32_t a_i,
    input  sint32_t b_i,
    output logic    busy_o,
    output logic    done_o,
    output sint32_t result_o
);

    md_state_t   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        neg_q, neg_d;
    logic        is_div_q, is_div_d;
    logic        div0_q, div0_d;

    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic [31:0] mag;

    // MUL: op_a = multiplicand (shifts left), op_b = multiplier (shifts right).
    // DIV: op_a = divisor, op_b = dividend shifting out / quotient shifting in.
    assign rem_sh  = {rem_q[31:0], op_b_q[31]};
    assign rem_sub = rem_sh - {1'b0, op_a_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        neg_d    = neg_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    is_div_d = is_div_i;
                    op_a_d   = is_div_i ? abs32(b_i) : abs32(a_i);
                    op_b_d   = is_div_i ? abs32(a_i) : abs32(b_i);
                    neg_d    = a_i[31] ^ b_i[31];
                    div0_d   = is_div_i && (b_i == '0);
                    acc_d    = '0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = (is_div_i && (b_i == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!rem_sub[32]) begin
                        rem_d  = rem_sub;
                        op_b_d = {op_b_q[30:0], 1'b1};
                    end else begin
                        rem_d  = rem_sh;
                        op_b_d = {op_b_q[30:0], 1'b0};
                    end
                end else begin
                    if (op_b_q[0]) begin
                        acc_d = acc_q + op_a_q;
                    end
                    op_a_d = {op_a_q[30:0], 1'b0};
                    op_b_d = {1'b0, op_b_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MD_STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            neg_q    <= neg_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

    // Sign correction on magnitudes also covers INT_MIN / -1 (magnitude 2^31, positive sign).
    assign mag      = is_div_q ? op_b_q : acc_q;
    assign result_o = div0_q ? sint32_t'(32'hFFFF_FFFF) : (neg_q ? sint32_t'(-mag) : sint32_t'(mag));
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus 33-stall-cycle iterative MUL/DIV; bubbles while stalled,
// flush forces a bubble with no stall. Optional stall counter behind EX_PERF_CNT_EN.
module ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    ex_stage_if.slave   ex_if
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    instruction_t ir;
    sint32_t      a_op;
    sint32_t      b_op;
    sint32_t      imm_op;
    logic         md_start;
    logic         md_busy;
    logic         md_done;
    sint32_t      md_result;

    assign ir     = ex_if.id_ex_pipe.IR;
    assign a_op   = ex_if.id_ex_pipe.A;
    assign b_op   = ex_if.id_ex_pipe.B;
    assign imm_op = ex_if.id_ex_pipe.Imm;

    ex_muldiv u_muldiv (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (md_start),
        .is_div_i (ir.opcode == DIV),
        .flush_i  (ex_if.flush),
        .a_i      (a_op),
        .b_i      (b_op),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // In DONE the ID/EX register still holds the MUL/DIV, so its IR is forwarded with the result.
    always_comb begin
        md_start      = 1'b0;
        ex_if.stall   = 1'b0;
        ex_if.IR_next = bubble_ir();
        ex_if.C_next  = '0;

        if (ex_if.flush) begin
            md_start = 1'b0;
        end else if (md_done) begin
            ex_if.IR_next = ir;
            ex_if.C_next  = md_result;
        end else if (md_busy) begin
            ex_if.stall = 1'b1;
        end else begin
            case (ir.opcode)
                NA: begin
                    ex_if.IR_next = ir;
                end
                ADD: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op + b_op;
                end
                SUB: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op - b_op;
                end
                AND: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op & b_op;
                end
                OR: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op | b_op;
                end
                XOR: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op ^ b_op;
                end
                SLT: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = {31'b0, (a_op < b_op)};
                end
                ADDI: begin
                    ex_if.IR_next = ir;
                    ex_if.C_next  = a_op + imm_op;
                end
                MUL, DIV: begin
                    md_start    = 1'b1;
                    ex_if.stall = 1'b1;
                end
                default: begin
                    ex_if.IR_next = bubble_ir();
                end
            endcase
        end
    end

    assign ex_if.md_busy = md_busy;

`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles_q <= '0;
        end else if (ex_if.stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
